// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one right-shift barrel datapath between two requesters.
// Round-robin grant, SLL via bit reversal, SRA via sign fill, and a single
// registered result slot (with a requester tag) on a valid/ready output.
module shift_arbiter #(
  parameter int N = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [1:0]           req0_op,
  input  logic [$clog2(N)-1:0] req0_amt,
  input  logic [N-1:0]         req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [1:0]           req1_op,
  input  logic [$clog2(N)-1:0] req1_amt,
  input  logic [N-1:0]         req1_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 out_id,
  output logic                 busy
);

  localparam int AW = $clog2(N);

  localparam logic [1:0] OP_SRL  = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_FULL = 1'b1;

  logic          r_state;
  logic          r_prio;
  logic [N-1:0]  r_data;
  logic          r_id;

  logic          w_can_grant;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_gid;
  logic [1:0]    w_op;
  logic [AW-1:0] w_amt;
  logic [N-1:0]  w_operand;
  logic [N-1:0]  w_result;

  // Mirror a word end-for-end so a left shift can reuse the right shifter.
  function automatic logic [N-1:0] f_reverse(input logic [N-1:0] d);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i] = d[N-1-i];
    end
    return r;
  endfunction

  // All four operations expressed around the single logical right shifter.
  function automatic logic [N-1:0] f_shift(input logic [1:0] op,
                                           input logic [AW-1:0] amt,
                                           input logic [N-1:0] d);
    logic [N-1:0] r;
    case (op)
      OP_SRL:  r = d >> amt;
      OP_SLL:  r = f_reverse(f_reverse(d) >> amt);
      OP_SRA:  r = (d >> amt) | (d[N-1] ? ~({N{1'b1}} >> amt) : {N{1'b0}});
      OP_PASS: r = d;
      default: r = d;
    endcase
    return r;
  endfunction

  // Grant selection: the slot is free or being drained, no grant during reset.
  always_comb begin
    w_can_grant = (r_state == ST_IDLE) || out_ready;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    if (!rst && w_can_grant) begin
      if (req0_valid && req1_valid) begin
        w_gnt0 = (r_prio == 1'b0);
        w_gnt1 = (r_prio == 1'b1);
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  // Operand mux for the granted requester feeding the shared shifter.
  always_comb begin
    w_gid = w_gnt1;
    if (w_gid) begin
      w_op      = req1_op;
      w_amt     = req1_amt;
      w_operand = req1_data;
    end else begin
      w_op      = req0_op;
      w_amt     = req0_amt;
      w_operand = req0_data;
    end
    w_result = f_shift(w_op, w_amt, w_operand);
  end

  // Result slot, requester tag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_prio  <= 1'b0;
      r_data  <= {N{1'b0}};
      r_id    <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_state <= ST_FULL;
      r_prio  <= ~w_gid;
      r_data  <= w_result;
      r_id    <= w_gid;
    end else if (r_state == ST_FULL && out_ready) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= r_state;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign out_valid  = (r_state == ST_FULL);
  assign busy       = (r_state == ST_FULL);
  assign out_data   = r_data;
  assign out_id     = r_id;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter (N=16): directed literal cases plus a
// randomized run compared every cycle against a behavioural reference model.
module tb_shift_arbiter;

  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [1:0]    req0_op, req1_op;
  logic [AW-1:0] req0_amt, req1_amt;
  logic [N-1:0]  req0_data, req1_data;
  logic          out_valid, out_ready, out_id, busy;
  logic [N-1:0]  out_data;

  int checks   = 0;
  int failures = 0;

  shift_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_amt(req0_amt), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_amt(req1_amt), .req1_data(req1_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shift semantics written with native operators.
  function automatic logic [N-1:0] model_shift(input logic [1:0] op, input logic [AW-1:0] amt,
                                               input logic [N-1:0] d);
    case (op)
      2'd0:    return d >> amt;
      2'd1:    return d << amt;
      2'd2:    return $signed(d) >>> amt;
      default: return d;
    endcase
  endfunction

  // Model state: what the output slot holds after the most recent edge.
  logic         m_full = 1'b0;
  logic [N-1:0] m_data = '0;
  logic         m_id   = 1'b0;
  logic         m_prio = 1'b0;

  // Per-cycle comparison against the model, then model advance for next edge.
  always @(negedge clk) begin
    int w;
    chk1("out_valid", out_valid, m_full);
    chk1("busy", busy, m_full);
    if (m_full) begin
      chk1("out_id", out_id, m_id);
      chk("out_data", out_data, m_data);
    end
    w = -1;
    if (!rst && (!m_full || out_ready)) begin
      if (req0_valid && req1_valid) w = m_prio ? 1 : 0;
      else if (req0_valid)          w = 0;
      else if (req1_valid)          w = 1;
    end
    chk1("req0_ready", req0_ready, w == 0);
    chk1("req1_ready", req1_ready, w == 1);
    if (rst) begin
      m_full = 1'b0; m_data = '0; m_id = 1'b0; m_prio = 1'b0;
    end else if (w >= 0) begin
      m_full = 1'b1;
      m_id   = (w == 1);
      m_data = (w == 1) ? model_shift(req1_op, req1_amt, req1_data)
                        : model_shift(req0_op, req0_amt, req0_data);
      m_prio = (w == 0);
    end else if (out_ready) begin
      m_full = 1'b0;
    end
  end

  task automatic send(input bit idx, input logic [1:0] op, input logic [AW-1:0] amt,
                      input logic [N-1:0] d, input logic [N-1:0] exp);
    @(posedge clk); #1;
    if (idx) begin
      req1_valid = 1'b1; req1_op = op; req1_amt = amt; req1_data = d;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_amt = amt; req0_data = d;
    end
    @(negedge clk);
    chk1("dir_ready", idx ? req1_ready : req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk1("dir_valid", out_valid, 1'b1);
    chk("dir_data", out_data, exp);
    chk1("dir_id", out_id, idx);
  endtask

  initial begin
    bit r0, r1;
    rst = 1'b1; out_ready = 1'b1;
    req0_valid = 1'b0; req0_op = 2'd0; req0_amt = '0; req0_data = '0;
    req1_valid = 1'b0; req1_op = 2'd0; req1_amt = '0; req1_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 16'h0000);
    chk1("rst_id", out_id, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    send(1'b0, 2'd0, 4'd4,  16'h8000, 16'h0800);
    send(1'b1, 2'd1, 4'd15, 16'h0001, 16'h8000);
    send(1'b0, 2'd2, 4'd3,  16'h8000, 16'hF000);
    send(1'b1, 2'd2, 4'd3,  16'h4000, 16'h0800);
    send(1'b0, 2'd3, 4'd7,  16'h1234, 16'h1234);
    send(1'b1, 2'd0, 4'd0,  16'hABCD, 16'hABCD);

    // Drain: exactly one valid cycle then idle.
    @(posedge clk); #1;
    @(negedge clk);
    chk1("drain_valid", out_valid, 1'b0);
    chk1("drain_busy", busy, 1'b0);

    // Alternation from a fresh reset.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req0_valid = 1'b1; req0_op = 2'd0; req0_amt = 4'd4; req0_data = 16'h00F0;
    req1_valid = 1'b1; req1_op = 2'd1; req1_amt = 4'd4; req1_data = 16'h00F0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk1("alt_id", out_id, k[0]);
      chk("alt_data", out_data, k[0] ? 16'h0F00 : 16'h000F);
    end

    // Backpressure: last edge granted requester 0; hold for three cycles.
    @(posedge clk); #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("bp_ready0", req0_ready, 1'b0);
      chk1("bp_ready1", req1_ready, 1'b0);
      chk1("bp_id", out_id, 1'b0);
      chk("bp_data", out_data, 16'h000F);
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk1("bp_release_ready1", req1_ready, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("bp_next_id", out_id, 1'b1);
    chk("bp_next_data", out_data, 16'h0F00);

    // Reset while holding a result under backpressure.
    @(posedge clk); #1 out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk1("rstmid_ready0", req0_ready, 1'b0);
    chk1("rstmid_ready1", req1_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("rstmid_valid", out_valid, 1'b0);
    chk("rstmid_data", out_data, 16'h0000);
    chk1("rstmid_prio0", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;

    // Randomized traffic; requests held stable until accepted.
    r0 = 1'b0; r1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!req0_valid || r0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_op = 2'($urandom_range(0, 3)); req0_amt = 4'($urandom_range(0, 15));
        req0_data = 16'($urandom);
      end
      if (!req1_valid || r1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op = 2'($urandom_range(0, 3)); req1_amt = 4'($urandom_range(0, 15));
        req1_data = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      r0 = req0_ready; r1 = req1_ready;
      @(posedge clk); #1;
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
